// File: rtl/dff_pkg.sv
// Shared types for the universal shift register: command opcodes and FSM states.
package dff_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_CLR  = 3'd2,
    OP_SHL  = 3'd3,
    OP_SHR  = 3'd4,
    OP_ASR  = 3'd5,
    OP_ROTL = 3'd6,
    OP_ROTR = 3'd7
  } shreg_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shreg_state_e;

endpackage

// File: rtl/shreg_step.sv
// One-bit step of the shift/rotate family; non-shift ops pass q through.
module shreg_step
  import dff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  shreg_op_e        op,
  input  logic [WIDTH-1:0] q,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SHL:  q_next = {q[WIDTH-2:0], sin_lsb};
      OP_SHR:  q_next = {sin_msb, q[WIDTH-1:1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROTR: q_next = {q[0], q[WIDTH-1:1]};
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: command port, one-bit-per-clock multi-step shifts
// under a two-state FSM, with busy/done status and an en stall.
module univ_shift_reg
  import dff_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 AMT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  shreg_op_e        cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] ONE   = AMT_W'(1);

  shreg_state_e     state, state_nxt;
  shreg_op_e        op_r, op_nxt, step_op;
  logic [AMT_W-1:0] cnt, cnt_nxt, n_eff;
  logic [WIDTH-1:0] q_nxt, q_step;
  logic             done_nxt;

  assign cmd_ready = (state == ST_IDLE) && en && !reset;
  assign qbar      = ~q;
  assign sout_msb  = q[WIDTH-1];
  assign sout_lsb  = q[0];
  assign busy      = (state == ST_SHIFT);
  assign n_eff     = (cmd_amt > W_AMT) ? W_AMT : cmd_amt;

  // The first step happens on the accept edge, so the step unit sees the
  // incoming op while idle and the captured op while shifting.
  assign step_op = (state == ST_SHIFT) ? op_r : cmd_op;

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .op      (step_op),
    .q       (q),
    .sin_lsb (sin_lsb),
    .sin_msb (sin_msb),
    .q_next  (q_step)
  );

  always_comb begin
    state_nxt = state;
    op_nxt    = op_r;
    cnt_nxt   = cnt;
    q_nxt     = q;
    done_nxt  = 1'b0;
    if (en) begin
      if (state == ST_SHIFT) begin
        q_nxt   = q_step;
        cnt_nxt = cnt - ONE;
        if (cnt == ONE) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end else if (cmd_valid) begin
        done_nxt = 1'b1;
        op_nxt   = cmd_op;
        case (cmd_op)
          OP_LOAD: q_nxt = d;
          OP_CLR:  q_nxt = '0;
          OP_SHL, OP_SHR, OP_ASR, OP_ROTL, OP_ROTR: begin
            if (n_eff != '0) q_nxt = q_step;
            if (n_eff > ONE) begin
              state_nxt = ST_SHIFT;
              cnt_nxt   = n_eff - ONE;
              done_nxt  = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      op_r  <= OP_NOP;
      cnt   <= '0;
      q     <= RESET_VAL;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      op_r  <= op_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_univ_shift_reg;
  import dff_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, cmd_valid, sin_lsb, sin_msb;
  shreg_op_e   cmd_op;
  logic [3:0]  cmd_amt;
  logic [7:0]  d;
  logic        cmd_ready, sout_msb, sout_lsb, busy, done;
  logic [7:0]  q, qbar;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .d(d), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
    .q(q), .qbar(qbar), .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register value as an int, plus number of steps still owed.
  int        m_q = 0;
  int        m_left = 0;
  shreg_op_e m_op = OP_NOP;
  bit        m_done = 1'b0;
  bit        chk_on = 1'b0;

  function automatic int step1(shreg_op_e op, int v, bit sl, bit sm);
    case (op)
      OP_SHL:  return ((v * 2) + sl) % 256;
      OP_SHR:  return (v / 2) + (sm ? 128 : 0);
      OP_ASR:  return (v / 2) + (v >= 128 ? 128 : 0);
      OP_ROTL: return ((v * 2) % 256) + (v / 128);
      OP_ROTR: return (v / 2) + ((v % 2) * 128);
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    chk_on <= 1'b1;
    if (reset) begin
      m_q = 0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (en) begin
        if (m_left > 0) begin
          m_q = step1(m_op, m_q, sin_lsb, sin_msb);
          m_left--;
          if (m_left == 0) m_done = 1;
        end else if (cmd_valid) begin
          int n;
          n = (cmd_amt > 8) ? 8 : int'(cmd_amt);
          case (cmd_op)
            OP_LOAD: begin m_q = int'(d); m_done = 1; end
            OP_CLR:  begin m_q = 0; m_done = 1; end
            OP_NOP:  m_done = 1;
            default: begin
              if (n > 0) m_q = step1(cmd_op, m_q, sin_lsb, sin_msb);
              m_op   = cmd_op;
              m_left = (n > 0) ? n - 1 : 0;
              m_done = (m_left == 0);
            end
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("q",         int'(q),         m_q);
      check("qbar",      int'(qbar),      255 - m_q);
      check("sout_msb",  int'(sout_msb),  m_q / 128);
      check("sout_lsb",  int'(sout_lsb),  m_q % 2);
      check("busy",      int'(busy),      int'(m_left > 0));
      check("done",      int'(done),      int'(m_done));
      check("cmd_ready", int'(cmd_ready), int'(m_left == 0 && en && !reset));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input shreg_op_e op, input logic [3:0] amt, input logic [7:0] dv);
    cmd_valid = 1'b1; cmd_op = op; cmd_amt = amt; d = dv;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_amt = '0;
    d = '0; sin_lsb = 1'b0; sin_msb = 1'b0;
    cyc(); cyc();
    check("rst_q", int'(q), 8'h00);
    check("rst_qbar", int'(qbar), 8'hFF);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 0);
    reset = 1'b0;
    #1 check("ready_after_rst", int'(cmd_ready), 1);

    // back-to-back loads
    cmd_valid = 1'b1; cmd_op = OP_LOAD; d = 8'hA5;
    cyc();
    check("load1_q", int'(q), 8'hA5);
    check("load1_qbar", int'(qbar), 8'h5A);
    check("load1_done", int'(done), 1);
    d = 8'h3C;
    cyc();
    cmd_valid = 1'b0;
    check("load2_q", int'(q), 8'h3C);
    check("load2_done", int'(done), 1);
    cyc();
    check("load_done_clr", int'(done), 0);

    // SHL by 3 with sin_lsb=1
    issue(OP_LOAD, 4'd0, 8'hA5);
    sin_lsb = 1'b1;
    issue(OP_SHL, 4'd3, 8'h00);
    check("shl_busy1", int'(busy), 1);
    cyc();
    check("shl_busy2", int'(busy), 1);
    check("shl_nodone", int'(done), 0);
    cyc();
    check("shl_q", int'(q), 8'h2F);
    check("shl_done", int'(done), 1);
    check("shl_idle", int'(busy), 0);
    sin_lsb = 1'b0;

    // ROTR by 4
    issue(OP_LOAD, 4'd0, 8'hA5);
    issue(OP_ROTR, 4'd4, 8'h00);
    cyc(); cyc(); cyc();
    check("rotr_q", int'(q), 8'h5A);
    check("rotr_done", int'(done), 1);

    // ASR with clamped amount, then zero amount
    issue(OP_LOAD, 4'd0, 8'h80);
    issue(OP_ASR, 4'd9, 8'h00);
    repeat (7) cyc();
    check("asr_q", int'(q), 8'hFF);
    check("asr_done", int'(done), 1);
    cyc();
    issue(OP_ASR, 4'd0, 8'h00);
    check("asr0_q", int'(q), 8'hFF);
    check("asr0_done", int'(done), 1);

    // SHR by 5 with a 2-cycle stall and an ignored command while busy
    issue(OP_LOAD, 4'd0, 8'hFF);
    issue(OP_SHR, 4'd5, 8'h00);
    cyc();
    en = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_LOAD; d = 8'h00;
    cyc();
    check("stall_q", int'(q), 8'h3F);
    cyc();
    check("stall_q2", int'(q), 8'h3F);
    en = 1'b1;
    cyc();
    check("shr_busy_ignore", int'(q), 8'h1F);
    cmd_valid = 1'b0;
    cyc();
    check("shr_nodone", int'(done), 0);
    cyc();
    check("shr_q", int'(q), 8'h07);
    check("shr_done", int'(done), 1);

    // reset aborts a shift
    issue(OP_LOAD, 4'd0, 8'h5A);
    issue(OP_SHL, 4'd6, 8'h00);
    cyc();
    reset = 1'b1;
    cyc();
    check("abort_q", int'(q), 8'h00);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 0);
    reset = 1'b0;
    issue(OP_LOAD, 4'd0, 8'h11);
    check("post_abort_q", int'(q), 8'h11);
    check("post_abort_done", int'(done), 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      en        = ($urandom_range(0, 4) != 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_op    = shreg_op_e'($urandom_range(0, 7));
      cmd_amt   = 4'($urandom_range(0, 15));
      d         = 8'($urandom);
      sin_lsb   = $urandom_range(0, 1);
      sin_msb   = $urandom_range(0, 1);
      cyc();
    end
    cmd_valid = 1'b0; reset = 1'b0; en = 1'b1;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
